uart_loader: RTL

UART_LOADER -- requirements
Module: uart_loader

---
 rtl/uart_loader_if.sv | 29 ++
 rtl/uart_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loader_if.sv
// Bus bundle for uart_loader: APB master towards the UART controller and a
// word-write port towards memory. The loader uses the master modport.
interface uart_loader_if;
    logic [3:0]  apb_PADDR;
    logic        apb_PSEL;
    logic        apb_PENABLE;
    logic        apb_PWRITE;
    logic [31:0] apb_PWDATA;
    logic        apb_PREADY;
    logic [31:0] apb_PRDATA;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;

    modport master (
        output apb_PADDR, apb_PSEL, apb_PENABLE, apb_PWRITE, apb_PWDATA,
        input  apb_PREADY, apb_PRDATA,
        output mem_valid, mem_addr, mem_wdata,
        input  mem_ready
    );

    modport slave (
        input  apb_PADDR, apb_PSEL, apb_PENABLE, apb_PWRITE, apb_PWDATA,
        output apb_PREADY, apb_PRDATA,
        input  mem_valid, mem_addr, mem_wdata,
        output mem_ready
    );
endinterface

// File: rtl/uart_loader.sv
// UART frame loader: polls an APB UART for SYNC/ADDR/LEN/DATA/CSUM frames and writes words to memory.
// Define UART_LOADER_ACK_EN to send an ACK/NAK byte back over the UART TX register at frame end.
module uart_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter logic [7:0] ACK_BYTE  = 8'h4B,
    parameter logic [7:0] NAK_BYTE  = 8'h45
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    uart_loader_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          error
);
    typedef enum logic [2:0] {
        S_SYNC, S_ADDR, S_LEN, S_DATA, S_CSUM, S_MEMWR, S_RESP, S_CLR
    } state_t;
    typedef enum logic [1:0] {A_IDLE, A_SETUP, A_ACCESS} apb_ph_t;

    state_t      state_q;
    apb_ph_t     aph_q;
    logic        psel_q, penable_q, pwrite_q;
    logic [3:0]  paddr_q;
    logic [31:0] pwdata_q;
    logic        mem_valid_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic        busy_q, done_q, error_q;
    logic [31:0] addr_q, word_q;
    logic [15:0] len_q;
    logic [1:0]  cnt_q;
    logic [7:0]  csum_q;
`ifdef UART_LOADER_ACK_EN
    logic [7:0]  resp_q;
    logic        resp_wr_q;
`else
    logic        unused_cfg;
    assign unused_cfg = ^{ACK_BYTE, NAK_BYTE};
`endif

    logic        req_d, req_wr_d;
    logic [3:0]  req_addr_d;
    logic [31:0] req_data_d;
    logic        xfer_done, rx_empty, rx_err;
    logic [7:0]  rx_byte;
    logic        unused_prdata;

    assign xfer_done     = (aph_q == A_ACCESS) && bus.apb_PREADY;
    assign rx_byte       = bus.apb_PRDATA[7:0];
    assign rx_err        = bus.apb_PRDATA[8];
    assign rx_empty      = bus.apb_PRDATA[31];
    assign unused_prdata = ^bus.apb_PRDATA[30:9];

    // Which APB transfer the parser wants next; MEMWR never touches the UART.
    always_comb begin
        req_d      = 1'b0;
        req_wr_d   = 1'b0;
        req_addr_d = 4'h0;
        req_data_d = 32'h0;
        case (state_q)
            S_SYNC, S_ADDR, S_LEN, S_DATA, S_CSUM: req_d = 1'b1;
            S_CLR: begin
                req_d    = 1'b1;
                req_wr_d = 1'b1;
            end
`ifdef UART_LOADER_ACK_EN
            S_RESP: begin
                req_d      = 1'b1;
                req_wr_d   = resp_wr_q;
                req_addr_d = 4'h4;
                req_data_d = {24'h0, resp_q};
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_SYNC;
            aph_q       <= A_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 4'h0;
            pwdata_q    <= 32'h0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef UART_LOADER_ACK_EN
            resp_wr_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (done_q) busy_q <= 1'b0;

            // Idle phase guarantees PSEL low for a cycle between transfers.
            case (aph_q)
                A_IDLE: if (req_d && en) begin
                    aph_q     <= A_SETUP;
                    psel_q    <= 1'b1;
                    penable_q <= 1'b0;
                    pwrite_q  <= req_wr_d;
                    paddr_q   <= req_addr_d;
                    pwdata_q  <= req_data_d;
                end
                A_SETUP: begin
                    aph_q     <= A_ACCESS;
                    penable_q <= 1'b1;
                end
                A_ACCESS: if (bus.apb_PREADY) begin
                    aph_q     <= A_IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
                default: aph_q <= A_IDLE;
            endcase

            if (xfer_done) begin
                case (state_q)
                    S_SYNC, S_ADDR, S_LEN, S_DATA, S_CSUM: begin
                        if (rx_err) begin
                            state_q <= S_CLR;
                            error_q <= 1'b1;
                        end else if (!rx_empty) begin
                            case (state_q)
                                S_SYNC: if (rx_byte == SYNC_BYTE) begin
                                    state_q <= S_ADDR;
                                    csum_q  <= 8'h0;
                                    cnt_q   <= 2'd0;
                                    busy_q  <= 1'b1;
                                    error_q <= 1'b0;
                                end
                                S_ADDR: begin
                                    csum_q                         <= csum_q + rx_byte;
                                    addr_q[{cnt_q, 3'b000} +: 8]   <= rx_byte;
                                    cnt_q                          <= cnt_q + 2'd1;
                                    if (cnt_q == 2'd3) begin
                                        state_q <= S_LEN;
                                        cnt_q   <= 2'd0;
                                    end
                                end
                                S_LEN: begin
                                    csum_q <= csum_q + rx_byte;
                                    if (cnt_q == 2'd0) begin
                                        len_q[7:0] <= rx_byte;
                                        cnt_q      <= 2'd1;
                                    end else begin
                                        len_q[15:8] <= rx_byte;
                                        cnt_q       <= 2'd0;
                                        state_q     <= ({rx_byte, len_q[7:0]} == 16'h0) ? S_CSUM : S_DATA;
                                    end
                                end
                                S_DATA: begin
                                    csum_q                       <= csum_q + rx_byte;
                                    word_q[{cnt_q, 3'b000} +: 8] <= rx_byte;
                                    cnt_q                        <= cnt_q + 2'd1;
                                    if (cnt_q == 2'd3) begin
                                        state_q     <= S_MEMWR;
                                        mem_valid_q <= 1'b1;
                                        mem_addr_q  <= {addr_q[31:2], 2'b00};
                                        mem_wdata_q <= {rx_byte, word_q[23:0]};
                                    end
                                end
                                default: begin
                                    if (rx_byte != csum_q) error_q <= 1'b1;
`ifdef UART_LOADER_ACK_EN
                                    resp_q    <= (rx_byte == csum_q) ? ACK_BYTE : NAK_BYTE;
                                    resp_wr_q <= 1'b0;
                                    state_q   <= S_RESP;
`else
                                    done_q    <= 1'b1;
                                    state_q   <= S_SYNC;
`endif
                                end
                            endcase
                        end
                    end
                    S_CLR: begin
`ifdef UART_LOADER_ACK_EN
                        resp_q    <= NAK_BYTE;
                        resp_wr_q <= 1'b0;
                        state_q   <= S_RESP;
`else
                        done_q    <= 1'b1;
                        state_q   <= S_SYNC;
`endif
                    end
`ifdef UART_LOADER_ACK_EN
                    S_RESP: begin
                        if (resp_wr_q) begin
                            resp_wr_q <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= S_SYNC;
                        end else if (!bus.apb_PRDATA[31]) begin
                            resp_wr_q <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end

            // Memory write is never gated by en or the pending checksum.
            if (state_q == S_MEMWR && mem_valid_q && bus.mem_ready) begin
                mem_valid_q <= 1'b0;
                addr_q      <= addr_q + 32'd4;
                len_q       <= len_q - 16'd1;
                state_q     <= (len_q == 16'd1) ? S_CSUM : S_DATA;
            end
        end
    end

    assign bus.apb_PSEL    = psel_q;
    assign bus.apb_PENABLE = penable_q;
    assign bus.apb_PWRITE  = pwrite_q;
    assign bus.apb_PADDR   = paddr_q;
    assign bus.apb_PWDATA  = pwdata_q;
    assign bus.mem_valid   = mem_valid_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
endmodule
